fifo_ctrl_dual: RTL and testbench

- Stream FIFO controller that sits directly upstream of mem_dual and drives it. It also consumes mem_dual's registered read data.
- Port 0 of the RAM is the write port; port 1 is the read port.
- Read data passes through a 2-entry output skid buffer, which absorbs the RAM's 1-cycle read latency and gives full throughput under backpressure.
- Provides valid/ready streaming in and out, with a level output and a synchronous flush.

---
 rtl/fifo_ctrl_dual.sv | 98 +++++++++
 tb/tb_fifo_ctrl_dual.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_dual.sv
// Stream FIFO controller driving a dual-port RAM (port 0 write, port 1 read).
// A 2-entry skid buffer absorbs the RAM's registered read latency.
module fifo_ctrl_dual #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic [WIDTH-1:0]  mem_data_0,
    output logic [ADDR_W-1:0] mem_address_0,
    output logic              mem_wren_0,
    output logic [WIDTH-1:0]  mem_data_1,
    output logic [ADDR_W-1:0] mem_address_1,
    output logic              mem_wren_1,
    input  logic [WIDTH-1:0]  mem_q_1
);
    localparam int CW = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH = CW'(1) << ADDR_W;

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   mem_count, mem_count_n, level_n;
    logic              rd_pend;
    logic [WIDTH-1:0]  slot [2];
    logic              skid_head, skid_tail;
    logic [1:0]        skid_count, skid_count_n;
    logic [2:0]        skid_occ;
    logic              in_fire, out_fire, issue;

    assign in_ready  = (mem_count < DEPTH) && !flush;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (skid_count != 2'd0);
    assign out_fire  = out_valid && out_ready;
    assign out_data  = slot[skid_head];

    // Skid occupancy once this cycle's pop and the in-flight word settle;
    // issuing only below 2 means the skid can never overflow.
    assign skid_occ = 3'(skid_count) + 3'(rd_pend) - 3'(out_fire);
    assign issue    = (mem_count != '0) && (skid_occ < 3'd2) && !flush;

    assign mem_wren_0    = in_fire;
    assign mem_address_0 = wr_ptr;
    assign mem_data_0    = in_data;
    assign mem_address_1 = rd_ptr;
    assign mem_data_1    = '0;
    assign mem_wren_1    = 1'b0;

    always_comb begin
        mem_count_n  = mem_count + CW'(in_fire) - CW'(issue);
        skid_count_n = skid_count + 2'(rd_pend) - 2'(out_fire);
        level_n      = mem_count_n + CW'(issue) + CW'(skid_count_n);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_count  <= '0;
            rd_pend    <= 1'b0;
            skid_head  <= 1'b0;
            skid_tail  <= 1'b0;
            skid_count <= '0;
            level      <= '0;
            slot[0]    <= '0;
            slot[1]    <= '0;
        end else if (flush) begin
            // Any word arriving on mem_q_1 this cycle is dropped.
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_count  <= '0;
            rd_pend    <= 1'b0;
            skid_head  <= 1'b0;
            skid_tail  <= 1'b0;
            skid_count <= '0;
            level      <= '0;
        end else begin
            wr_ptr     <= wr_ptr + ADDR_W'(in_fire);
            rd_ptr     <= rd_ptr + ADDR_W'(issue);
            mem_count  <= mem_count_n;
            rd_pend    <= issue;
            skid_count <= skid_count_n;
            level      <= level_n;
            if (rd_pend) begin
                slot[skid_tail] <= mem_q_1;
                skid_tail       <= ~skid_tail;
            end
            if (out_fire)
                skid_head <= ~skid_head;
        end
    end
endmodule

// File: tb/tb_fifo_ctrl_dual.sv
// Scoreboard bench for fifo_ctrl_dual with a behavioural registered-read RAM.
module tb_fifo_ctrl_dual;
    localparam int WIDTH = 8, ADDR_W = 6;

    logic clock = 1'b0, reset = 1'b1, flush = 1'b0;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic mem_wren_0, mem_wren_1;
    logic [WIDTH-1:0] in_data = '0, out_data, mem_data_0, mem_data_1, mem_q_1;
    logic [ADDR_W-1:0] mem_address_0, mem_address_1;
    logic [ADDR_W:0] level;
    logic [WIDTH-1:0] ram [2**ADDR_W];

    fifo_ctrl_dual #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level),
        .mem_data_0(mem_data_0), .mem_address_0(mem_address_0), .mem_wren_0(mem_wren_0),
        .mem_data_1(mem_data_1), .mem_address_1(mem_address_1), .mem_wren_1(mem_wren_1),
        .mem_q_1(mem_q_1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_wren_0) ram[mem_address_0] <= mem_data_0;
        mem_q_1 <= ram[mem_address_1];
    end

    int checks = 0, errors = 0, cyc = 0;
    int n_out = 0, first_out = 0, last_out = 0, fire_cyc = 0;
    logic [WIDTH-1:0] exp_q [$];
    logic stall_prev = 1'b0;
    logic [WIDTH-1:0] stall_data = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected words whenever the DUT hands one over.
    always @(negedge clock) begin
        if (reset) stall_prev = 1'b0;
        else begin
            if (stall_prev) check("stall_hold", {out_valid, out_data}, {1'b1, stall_data});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out", {1'b1, out_data}, 0);
                else check("out_data", out_data, exp_q.pop_front());
                if (n_out == 0) first_out = cyc;
                last_out = cyc;
                n_out++;
            end
            stall_prev = out_valid && !out_ready && !flush;
            stall_data = out_data;
        end
    end

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, output int stalls);
        logic acc = 1'b0;
        int t = 0;
        stalls = 0;
        in_valid = 1'b1; in_data = d;
        while (!acc && t < 500) begin
            @(negedge clock);
            acc = in_ready;
            if (acc) begin exp_q.push_back(d); fire_cyc = cyc; end
            else stalls++;
            step();
            t++;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((level != 0 || exp_q.size() != 0) && t < 5000) begin step(); t++; end
        check("drain_done", (t < 5000), 1);
        check("drain_level", level, 0);
    endtask

    initial begin
        int s, tot, k, sent;
        // Reset state
        #1; check("rst_out_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_wren0", mem_wren_0, 0);
        step(); reset = 1'b0; step();
        @(negedge clock); check("rst_in_ready", in_ready, 1);
        step();

        // Single word latency
        out_ready = 1'b1; n_out = 0;
        send(8'hA5, s);
        @(negedge clock); check("single_level1", level, 1);
        wait_drain();
        check("single_latency", first_out - fire_cyc, 3);

        // Streaming 200 words
        n_out = 0; tot = 0;
        for (int i = 0; i < 200; i++) begin send(8'(i), s); tot += s; end
        wait_drain();
        check("stream_in_stalls", tot, 0);
        check("stream_count", n_out, 200);
        check("stream_no_bubbles", last_out - first_out, 199);

        // Fill to capacity
        out_ready = 1'b0; k = 0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h40 + i);
            @(negedge clock);
            if (!in_ready) break;
            exp_q.push_back(in_data); k++;
            step();
        end
        in_valid = 1'b0;
        step(); step();
        check("fill_accepted", k, 66);
        check("fill_level", level, 66);
        @(negedge clock); check("fill_in_ready", in_ready, 0);
        step();
        out_ready = 1'b1; n_out = 0;
        wait_drain();
        check("fill_drain_count", n_out, 66);

        // Random valid/ready, 1000 words
        sent = 0;
        for (int t = 0; t < 20000 && sent < 1000; t++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'(sent * 7 + 3);
            @(negedge clock);
            if (in_valid && in_ready) begin exp_q.push_back(in_data); sent++; end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("rand_sent", sent, 1000);
        wait_drain();

        // Flush with level 10 and a read in flight
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) send(8'(8'hC0 + i), s);
        repeat (4) step();
        check("pre_flush_level", level, 12);
        out_ready = 1'b1; step();
        step();
        out_ready = 1'b0; flush = 1'b1;
        @(negedge clock);
        check("flush_level_before", level, 10);
        check("flush_in_ready", in_ready, 0);
        step(); flush = 1'b0;
        exp_q.delete();
        @(negedge clock);
        check("flush_level_after", level, 0);
        check("flush_out_valid", out_valid, 0);
        step();
        out_ready = 1'b1; n_out = 0;
        send(8'h3C, s);
        wait_drain();
        check("flush_next_count", n_out, 1);

        // Async reset mid-stream with level 5
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(8'(8'h80 + i), s);
        repeat (3) step();
        check("pre_reset_level", level, 5);
        #2 reset = 1'b1; #1;
        check("reset_async_valid", out_valid, 0);
        check("reset_async_level", level, 0);
        exp_q.delete();
        step(); reset = 1'b0; step();
        out_ready = 1'b1; n_out = 0;
        send(8'h11, s); send(8'h22, s);
        wait_drain();
        check("reset_after_count", n_out, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
